// File: rtl/tpu_pkg.sv
// Shared types and saturating arithmetic for the systolic matmul engine.
// Limits are computed on 64-bit signed values so one helper serves both modes.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic SGN_UNSIGNED = 1'b0;
  localparam logic SGN_SIGNED   = 1'b1;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } sat_res_t;

  function automatic logic signed [63:0] sat_hi(input logic mode, input int w);
    if (mode == SGN_SIGNED) return (64'sd1 <<< (w - 1)) - 64'sd1;
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input logic mode, input int w);
    if (mode == SGN_SIGNED) return -(64'sd1 <<< (w - 1));
    return 64'sd0;
  endfunction

  // x and y arrive already extended to 64 bits according to mode.
  function automatic sat_res_t sat_add(input logic signed [63:0] x, input logic signed [63:0] y,
                                       input logic mode, input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t r;
    s  = x + y;
    hi = sat_hi(mode, w);
    lo = sat_lo(mode, w);
    r.ovf = 1'b0;
    r.val = s;
    if (s > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_pe.sv
// One output-stationary MAC cell: registered a/b pass-through, saturating
// accumulator and a sticky saturation flag, both cleared by clr.
module sys_pe
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  sgn,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic signed [PW-1:0]  prod_s;
  logic [PW-1:0]         prod_u;
  logic signed [63:0]    acc_x, prod_x;
  sat_res_t              sum;

  always_comb begin
    prod_s = $signed({{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in}) *
             $signed({{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in});
    prod_u = {{DATA_WIDTH{1'b0}}, a_in} * {{DATA_WIDTH{1'b0}}, b_in};
    if (sgn == SGN_SIGNED) begin
      acc_x  = {{(64-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
      prod_x = {{(64-PW){prod_s[PW-1]}}, prod_s};
    end else begin
      acc_x  = {{(64-ACC_WIDTH){1'b0}}, acc_q};
      prod_x = {{(64-PW){1'b0}}, prod_u};
    end
    sum = sat_add(acc_x, prod_x, sgn, ACC_WIDTH);
    a_d = a_in;
    b_d = b_in;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      acc_d = sum.val[ACC_WIDTH-1:0];
      ovf_d = ovf_q | sum.ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/systolic_array_seq.sv
// Output-stationary ROWS x COLS matmul engine with internal operand skewing,
// start/busy/done job control and valid/ready operand streaming.
//
// state | meaning
// IDLE  | waiting for start
// FEED  | accepting K beats of operands (in_ready high)
// DRAIN | flushing zeros until the far corner PE has its last product
// DONE  | one-cycle done pulse; start here chains the next job
module systolic_array_seq
  import tpu_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int K_W        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [K_W-1:0]                  k_len,
  input  logic                            sgn,
  output logic                            busy,
  output logic                            done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]      a_vec,
  input  logic [COLS*DATA_WIDTH-1:0]      b_vec,
  output logic [ROWS*COLS*ACC_WIDTH-1:0]  c_out,
  output logic                            ovf
);

  localparam int DRAIN_CYC = ROWS + COLS - 2;
  localparam int DRN_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

  state_t           state_q, state_d;
  logic [K_W-1:0]   beat_q, beat_d, klen_q, klen_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             sgn_q, sgn_d, busy_q, busy_d, done_q, done_d, in_ready_q, in_ready_d;
  logic             start_ok, accept;

  assign accept   = in_valid && in_ready_q;
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    klen_d  = klen_q;
    drain_d = drain_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          klen_d = k_len;
          sgn_d  = sgn;
          beat_d = '0;
          if (k_len == '0) begin
            state_d = ST_DRAIN;
            drain_d = DRN_W'(DRAIN_CYC);
          end else begin
            state_d = ST_FEED;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (accept) begin
          if (beat_q == klen_q - 1'b1) begin
            state_d = ST_DRAIN;
            drain_d = DRN_W'(DRAIN_CYC);
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d == ST_FEED) || (state_d == ST_DRAIN);
    in_ready_d = (state_d == ST_FEED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      klen_q     <= '0;
      drain_q    <= '0;
      sgn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      klen_q     <= klen_d;
      drain_q    <= drain_d;
      sgn_q      <= sgn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;

  logic [DATA_WIDTH-1:0] a_edge [ROWS];
  logic [DATA_WIDTH-1:0] b_edge [COLS];

  // Triangular skew: row i / column j get i / j delay stages; bubbles inject zeros.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    logic [DATA_WIDTH-1:0] a_row;
    assign a_row = accept ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_row;
    end else begin : g_regs
      logic [DATA_WIDTH-1:0] sk_q [i];
      logic [DATA_WIDTH-1:0] sk_d [i];
      always_comb begin
        sk_d[0] = a_row;
        for (int t = 1; t < i; t++) sk_d[t] = sk_q[t-1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int t = 0; t < i; t++) sk_q[t] <= '0;
        end else begin
          for (int t = 0; t < i; t++) sk_q[t] <= sk_d[t];
        end
      end
      assign a_edge[i] = sk_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    logic [DATA_WIDTH-1:0] b_col;
    assign b_col = accept ? b_vec[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (j == 0) begin : g_direct
      assign b_edge[j] = b_col;
    end else begin : g_regs
      logic [DATA_WIDTH-1:0] sk_q [j];
      logic [DATA_WIDTH-1:0] sk_d [j];
      always_comb begin
        sk_d[0] = b_col;
        for (int t = 1; t < j; t++) sk_d[t] = sk_q[t-1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int t = 0; t < j; t++) sk_q[t] <= '0;
        end else begin
          for (int t = 0; t < j; t++) sk_q[t] <= sk_d[t];
        end
      end
      assign b_edge[j] = sk_q[j-1];
    end
  end

  logic [DATA_WIDTH-1:0] a_link [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] b_link [ROWS+1][COLS];
  logic [ROWS*COLS-1:0]  ovf_w;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign a_link[i][0] = a_edge[i];
    for (genvar j = 0; j < COLS; j++) begin : g_col
      if (i == 0) begin : g_btop
        assign b_link[0][j] = b_edge[j];
      end
      sys_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .sgn  (sgn_q),
        .a_in (a_link[i][j]),
        .b_in (b_link[i][j]),
        .a_out(a_link[i][j+1]),
        .b_out(b_link[i+1][j]),
        .acc  (c_out[(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH]),
        .ovf  (ovf_w[i*COLS+j])
      );
    end
  end

  assign ovf = |ovf_w;

endmodule
